// File: rtl/path_odometer_pkg.sv
// Shared definitions for the path odometer and the distance stage it feeds.
//   - FSM state encoding
//   - coordinate/distance widths
//   - default distance-stage latency, so the odometer and the distance
//     pipeline take their depth from a single place
package path_odometer_pkg;

  localparam int X_W         = 11;  // centroid x width
  localparam int Y_W         = 10;  // centroid y width
  localparam int D_W         = 12;  // distance width
  localparam int DEF_LATENCY = 24;  // distance-stage pipeline depth

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,  // no previous point held
    ST_READY   = 2'd1,  // previous point held, idle
    ST_MEASURE = 2'd2   // waiting LATENCY cycles for the distance to settle
  } odo_state_t;

endpackage

// File: rtl/path_odometer_accum.sv
// Saturating path-length accumulator.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   clear        zero total and overflow (wins over a same-cycle add)
//   add_en       add add_val this cycle
//   add_val      D_W-bit step length, zero-extended before the add
//   total        ACC_W-bit accumulated length, clamps at all-ones
//   overflow     sticky, set when an unclipped sum exceeded all-ones
module odo_accum
  import path_odometer_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [D_W-1:0]   add_val,
  output logic [ACC_W-1:0] total,
  output logic             overflow
);

  // The adder is one bit wider than the wider operand. With ACC_W >= D_W this
  // is ACC_W+1 bits and the saturation test is just the carry; a narrow
  // ACC_W still saturates correctly on a step that alone exceeds the range.
  localparam int OP_W  = (ACC_W > D_W) ? ACC_W : D_W;
  localparam int SUM_W = OP_W + 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] max_v;
  logic             sat;

  always_comb begin
    max_v = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};
    sum   = {{(SUM_W - ACC_W){1'b0}}, total} + {{(SUM_W - D_W){1'b0}}, add_val};
    sat   = (sum > max_v);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      total    <= '0;
      overflow <= 1'b0;
    end else if (add_en) begin
      total <= sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      if (sat) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/path_odometer.sv
// Path odometer: turns a stream of tracked centroid samples into start/end
// coordinate pairs for an external distance stage, samples the settled
// distance LATENCY cycles later and accumulates total path length.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   pt_valid            one-cycle strobe, new centroid on pt_x/pt_y
//   pt_x, pt_y          centroid coordinates
//   track_lost          target lost, forget previous point / abandon step
//   clear               zero total and overflow
//   x_start..y_end      registered coordinate pair to the distance stage
//   distance            settled distance from the distance stage
//   step, step_valid    last sampled distance, one-cycle update strobe
//   total, overflow     saturating accumulated length, sticky saturation flag
//   busy                measurement in progress
//   dropped             one-cycle strobe, a pt_valid was ignored while busy
module path_odometer
  import path_odometer_pkg::*;
#(
  parameter int LATENCY  = DEF_LATENCY,
  parameter int MIN_STEP = 2,
  parameter int ACC_W    = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pt_valid,
  input  logic [X_W-1:0]   pt_x,
  input  logic [Y_W-1:0]   pt_y,
  input  logic             track_lost,
  input  logic             clear,
  output logic [X_W-1:0]   x_start,
  output logic [X_W-1:0]   x_end,
  output logic [Y_W-1:0]   y_start,
  output logic [Y_W-1:0]   y_end,
  input  logic [D_W-1:0]   distance,
  output logic [D_W-1:0]   step,
  output logic             step_valid,
  output logic [ACC_W-1:0] total,
  output logic             overflow,
  output logic             busy,
  output logic             dropped
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  odo_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [X_W-1:0]   prev_x;
  logic [Y_W-1:0]   prev_y;

  logic load_first;  // first point after EMPTY: zero-length pair
  logic load_step;   // second+ point: launch a measurement
  logic do_sample;   // distance settled this cycle
  logic drop_d;      // pt_valid arrived while measuring
  logic add_en;

  // Next state and per-cycle controls. track_lost overrides everything,
  // including a coincident pt_valid and a pending sample.
  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_step  = 1'b0;
    do_sample  = 1'b0;
    drop_d     = 1'b0;
    if (track_lost) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (pt_valid) begin
            load_first = 1'b1;
            state_d    = ST_READY;
          end
        end
        ST_READY: begin
          if (pt_valid) begin
            load_step = 1'b1;
            state_d   = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // A point arriving on the sampling edge is still dropped; the
          // next point is accepted from READY, i.e. after step_valid.
          if (pt_valid) drop_d = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            do_sample = 1'b1;
            state_d   = ST_READY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      x_start    <= '0;
      x_end      <= '0;
      y_start    <= '0;
      y_end      <= '0;
      step       <= '0;
      step_valid <= 1'b0;
      busy       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      step_valid <= do_sample;
      dropped    <= drop_d;
      busy       <= (state_d == ST_MEASURE);

      if (track_lost) begin
        cnt_q <= '0;
      end else if (load_step) begin
        cnt_q <= CNT_W'(LATENCY);
      end else if (state_q == ST_MEASURE) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (load_first) begin
        prev_x  <= pt_x;
        prev_y  <= pt_y;
        x_start <= pt_x;
        x_end   <= pt_x;
        y_start <= pt_y;
        y_end   <= pt_y;
      end

      if (load_step) begin
        x_start <= prev_x;
        y_start <= prev_y;
        x_end   <= pt_x;
        y_end   <= pt_y;
        prev_x  <= pt_x;
        prev_y  <= pt_y;
      end

      if (do_sample) step <= distance;
    end
  end

  // Jitter deadband: short steps are reported but not accumulated.
  assign add_en = do_sample && (distance >= D_W'(MIN_STEP));

  odo_accum #(
    .ACC_W (ACC_W)
  ) u_accum (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .add_en   (add_en),
    .add_val  (distance),
    .total    (total),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_path_odometer.sv
// Bench for path_odometer: two instances (default ACC_W and ACC_W=6), each
// fed by a model distance stage; expected steps go to a scoreboard queue
// when the point is driven and are compared when step_valid appears.
module tb_path_odometer;
  import path_odometer_pkg::*;

  localparam int LAT = DEF_LATENCY;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int due;
    int st;
    int tot;
    bit ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // ---------------- DUT A (ACC_W = 20) ----------------
  logic             a_reset = 1'b1, a_pt_valid = 1'b0, a_track_lost = 1'b0, a_clear = 1'b0;
  logic [X_W-1:0]   a_pt_x = '0;
  logic [Y_W-1:0]   a_pt_y = '0;
  logic [X_W-1:0]   a_xs, a_xe;
  logic [Y_W-1:0]   a_ys, a_ye;
  logic [D_W-1:0]   a_dist, a_step;
  logic [19:0]      a_total;
  logic             a_sv, a_ovf, a_busy, a_drop;

  path_odometer #(.LATENCY(LAT), .MIN_STEP(2), .ACC_W(20)) u_a (
    .clk(clk), .reset(a_reset), .pt_valid(a_pt_valid), .pt_x(a_pt_x), .pt_y(a_pt_y),
    .track_lost(a_track_lost), .clear(a_clear),
    .x_start(a_xs), .x_end(a_xe), .y_start(a_ys), .y_end(a_ye),
    .distance(a_dist), .step(a_step), .step_valid(a_sv), .total(a_total),
    .overflow(a_ovf), .busy(a_busy), .dropped(a_drop)
  );

  // ---------------- DUT B (ACC_W = 6) ----------------
  logic             b_reset = 1'b1, b_pt_valid = 1'b0, b_track_lost = 1'b0, b_clear = 1'b0;
  logic [X_W-1:0]   b_pt_x = '0;
  logic [Y_W-1:0]   b_pt_y = '0;
  logic [X_W-1:0]   b_xs, b_xe;
  logic [Y_W-1:0]   b_ys, b_ye;
  logic [D_W-1:0]   b_dist, b_step;
  logic [5:0]       b_total;
  logic             b_sv, b_ovf, b_busy, b_drop;

  path_odometer #(.LATENCY(LAT), .MIN_STEP(2), .ACC_W(6)) u_b (
    .clk(clk), .reset(b_reset), .pt_valid(b_pt_valid), .pt_x(b_pt_x), .pt_y(b_pt_y),
    .track_lost(b_track_lost), .clear(b_clear),
    .x_start(b_xs), .x_end(b_xe), .y_start(b_ys), .y_end(b_ye),
    .distance(b_dist), .step(b_step), .step_valid(b_sv), .total(b_total),
    .overflow(b_ovf), .busy(b_busy), .dropped(b_drop)
  );

  // ---------------- distance stage model ----------------
  // Rounded Euclidean distance; new coordinates are seen combinationally and
  // pass LAT-1 registers, so the value settles LAT cycles after they appear.
  function automatic int rdist(logic [X_W-1:0] x0, logic [X_W-1:0] x1,
                               logic [Y_W-1:0] y0, logic [Y_W-1:0] y1);
    int dx, dy, s, n;
    dx = int'(x1) - int'(x0);
    dy = int'(y1) - int'(y0);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    s = dx * dx + dy * dy;
    n = 0;
    while ((n + 1) * (n + 1) <= s) n++;
    if (s - n * n > n) n++;
    return n;
  endfunction

  logic [D_W-1:0] a_pipe [LAT-1];
  logic [D_W-1:0] b_pipe [LAT-1];

  always @(posedge clk) begin
    a_pipe[0] <= D_W'(rdist(a_xs, a_xe, a_ys, a_ye));
    b_pipe[0] <= D_W'(rdist(b_xs, b_xe, b_ys, b_ye));
    for (int i = 1; i < LAT - 1; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end

  assign a_dist = a_pipe[LAT-2];
  assign b_dist = b_pipe[LAT-2];

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (a_sv) begin
      if (qa.size() == 0) chk("a_unexpected_step", 32'(a_sv), 0);
      else begin
        e = qa.pop_front();
        chk("a_step_cycle", cyc, e.due);
        chk("a_step", 32'(a_step), e.st);
        chk("a_total", 32'(a_total), e.tot);
        chk("a_overflow", 32'(a_ovf), 32'(e.ovf));
      end
    end else if (qa.size() > 0 && cyc >= qa[0].due) begin
      chk("a_missing_step", 32'(a_sv), 1);
      void'(qa.pop_front());
    end
    if (b_sv) begin
      if (qb.size() == 0) chk("b_unexpected_step", 32'(b_sv), 0);
      else begin
        e = qb.pop_front();
        chk("b_step_cycle", cyc, e.due);
        chk("b_step", 32'(b_step), e.st);
        chk("b_total", 32'(b_total), e.tot);
        chk("b_overflow", 32'(b_ovf), 32'(e.ovf));
      end
    end else if (qb.size() > 0 && cyc >= qb[0].due) begin
      chk("b_missing_step", 32'(b_sv), 1);
      void'(qb.pop_front());
    end
  endtask

  // Advance one cycle; sample #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  // Bench's own record of A's previous accepted point.
  int a_px = 0, a_py = 0;
  bit a_has_prev = 0;

  task automatic send_a(input int x, input int y, input bit drop, input bit has_step,
                        input int es, input int et, input bit eo);
    int c;
    int ex0, ey0, oxs, oxe;
    c = cyc;
    oxs = int'(a_xs);
    oxe = int'(a_xe);
    a_pt_x = X_W'(x);
    a_pt_y = Y_W'(y);
    a_pt_valid = 1'b1;
    if (has_step) qa.push_back('{c + LAT + 1, es, et, eo});
    tick();
    a_pt_valid = 1'b0;
    chk("a_dropped", 32'(a_drop), 32'(drop));
    if (drop) begin
      chk("a_drop_xs_hold", 32'(a_xs), oxs);
      chk("a_drop_xe_hold", 32'(a_xe), oxe);
      chk("a_drop_busy", 32'(a_busy), 1);
    end else begin
      ex0 = a_has_prev ? a_px : x;
      ey0 = a_has_prev ? a_py : y;
      chk("a_x_start", 32'(a_xs), ex0);
      chk("a_x_end", 32'(a_xe), x);
      chk("a_y_start", 32'(a_ys), ey0);
      chk("a_y_end", 32'(a_ye), y);
      chk("a_busy", 32'(a_busy), 32'(a_has_prev));
      a_px = x;
      a_py = y;
      a_has_prev = 1;
    end
  endtask

  task automatic send_b(input int x, input int y, input bit has_step,
                        input int es, input int et, input bit eo);
    b_pt_x = X_W'(x);
    b_pt_y = Y_W'(y);
    b_pt_valid = 1'b1;
    if (has_step) qb.push_back('{cyc + LAT + 1, es, et, eo});
    tick();
    b_pt_valid = 1'b0;
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_xs"}, 32'(a_xs), 0);
    chk({tag, "_xe"}, 32'(a_xe), 0);
    chk({tag, "_ys"}, 32'(a_ys), 0);
    chk({tag, "_ye"}, 32'(a_ye), 0);
    chk({tag, "_step"}, 32'(a_step), 0);
    chk({tag, "_sv"}, 32'(a_sv), 0);
    chk({tag, "_total"}, 32'(a_total), 0);
    chk({tag, "_ovf"}, 32'(a_ovf), 0);
    chk({tag, "_busy"}, 32'(a_busy), 0);
    chk({tag, "_drop"}, 32'(a_drop), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c;

    tick();
    tick();
    a_reset = 1'b0;
    b_reset = 1'b0;
    check_zero_a("a_reset");
    chk("b_reset_total", 32'(b_total), 0);
    chk("b_reset_sv", 32'(b_sv), 0);

    // (0,0) then (3,4): zero-length first pair, then a 5 step
    send_a(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    send_a(3, 4, 0, 1, 5, 5, 0);
    repeat (LAT + 2) tick();

    // sub-deadband step is reported but not accumulated
    send_a(4, 4, 0, 1, 1, 5, 0);
    repeat (LAT + 2) tick();
    send_a(10, 12, 0, 1, 10, 15, 0);
    repeat (LAT + 2) tick();

    // second point 3 cycles into a measurement is dropped
    send_a(100, 0, 0, 1, 91, 106, 0);
    tick(); tick();
    send_a(200, 0, 1, 0, 0, 0, 0);
    repeat (LAT + 2) tick();
    send_a(100, 20, 0, 1, 20, 126, 0);
    repeat (LAT + 2) tick();

    // track_lost mid-measure abandons the step
    send_a(103, 24, 0, 0, 0, 0, 0);
    repeat (5) tick();
    a_track_lost = 1'b1;
    tick();
    a_track_lost = 1'b0;
    chk("a_lost_busy", 32'(a_busy), 0);
    chk("a_lost_xs_hold", 32'(a_xs), 100);
    chk("a_lost_xe_hold", 32'(a_xe), 103);
    chk("a_lost_total_hold", 32'(a_total), 126);
    chk("a_lost_step_hold", 32'(a_step), 20);
    a_has_prev = 0;
    // pt_valid together with track_lost is discarded silently
    a_pt_x = X_W'(7);
    a_pt_y = Y_W'(7);
    a_pt_valid = 1'b1;
    a_track_lost = 1'b1;
    tick();
    a_pt_valid = 1'b0;
    a_track_lost = 1'b0;
    chk("a_lostpt_dropped", 32'(a_drop), 0);
    chk("a_lostpt_xe_hold", 32'(a_xe), 103);
    repeat (LAT + 2) tick();
    send_a(500, 300, 0, 0, 0, 0, 0);
    tick(); tick();
    send_a(503, 304, 0, 1, 5, 131, 0);
    repeat (LAT + 2) tick();

    // reset two cycles into a measurement
    send_a(506, 308, 0, 0, 0, 0, 0);
    tick();
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    check_zero_a("a_midreset");
    a_has_prev = 0;
    repeat (LAT + 2) tick();
    send_a(1, 1, 0, 0, 0, 0, 0);
    tick(); tick();
    send_a(4, 5, 0, 1, 5, 5, 0);
    repeat (LAT + 2) tick();

    // narrow accumulator: saturation, clear, clear on the sampling edge
    send_b(0, 0, 0, 0, 0, 0);
    tick(); tick();
    send_b(50, 0, 1, 50, 50, 0);
    repeat (LAT + 2) tick();
    send_b(100, 0, 1, 50, 63, 1);
    repeat (LAT + 2) tick();
    chk("b_sat_total", 32'(b_total), 63);
    chk("b_sat_ovf", 32'(b_ovf), 1);
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    chk("b_clear_total", 32'(b_total), 0);
    chk("b_clear_ovf", 32'(b_ovf), 0);
    tick();
    c = cyc;
    send_b(103, 4, 1, 5, 0, 0);
    while (cyc < c + LAT) tick();
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    repeat (3) tick();
    chk("b_clearedge_step", 32'(b_step), 5);
    chk("b_clearedge_total", 32'(b_total), 0);

    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
